// File: rtl/lsu_multibeat_if.sv
// lsu_multibeat_if: request/response and memory-beat signals of the load/store unit.
// master = requester plus memory side (core/bench), slave = the LSU itself.
interface lsu_multibeat_if #(parameter int XLEN = 32, parameter int ADDR_W = 32);
  localparam int NB = XLEN / 8;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_adr;
  logic              mem_we;
  logic [NB-1:0]     mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_valid, mem_adr, mem_we, mem_be, mem_wdata
  );
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_valid, mem_adr, mem_we, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_multibeat.sv
// lsu_multibeat: load/store unit producing aligned memory beats with byte enables and extended load data.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned accesses into two beats instead of erroring.
module lsu_multibeat #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic rst_n,
  lsu_multibeat_if.slave bus
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_e;
  state_e state_q, state_d;
  logic                write_q, uns_q, split_q, err_q;
  logic [1:0]          sz_q;
  logic [OW-1:0]       off_q;
  logic [ADDR_W-1:0]   adr_q;
  logic [2*NB-1:0]     be_q;
  logic [2*XLEN-1:0]   wd_q;
  logic [XLEN-1:0]     rd0_q, rd1_q;
  logic [2:0]          f3;
  logic [1:0]          sz;
  logic [OW-1:0]       off;
  logic                illegal, mis, err;
  logic [2*NB-1:0]     m2, be2;
  logic [2*XLEN-1:0]   wd2, rd2;
  logic [XLEN-1:0]     lo, keep, msb, ext;
  logic                sign, b1;
  always_comb begin
    f3      = bus.req_funct3;
    sz      = f3[1:0];
    off     = bus.req_addr[OW-1:0];
    illegal = (f3 == 3'b111) || (f3 == 3'b011 && XLEN != 64) ||
              (f3 == 3'b110 && XLEN != 64) || (bus.req_write && f3[2]);
    mis     = (int'(off) + (1 << sz)) > NB;
    err     = illegal || (mis && !SPLIT);
    m2      = (2*NB)'((1 << (1 << sz)) - 1);
    be2     = m2 << off;
    wd2     = {{XLEN{1'b0}}, bus.req_wdata} << (8 * off);
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.req_valid ? (err ? RESP : BEAT0) : IDLE;
      BEAT0:   state_d = bus.mem_ready ? (split_q ? BEAT1 : RESP) : BEAT0;
      BEAT1:   state_d = bus.mem_ready ? RESP : BEAT1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  // Shifted lanes for both beats are prepared once at accept time so the beats only mux halves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      sz_q    <= '0;
      off_q   <= '0;
      adr_q   <= '0;
      be_q    <= '0;
      wd_q    <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      if (state_q == IDLE && bus.req_valid) begin
        write_q <= bus.req_write;
        uns_q   <= f3[2];
        split_q <= mis && !illegal;
        err_q   <= err;
        sz_q    <= sz;
        off_q   <= off;
        adr_q   <= {bus.req_addr[ADDR_W-1:OW], {OW{1'b0}}};
        be_q    <= be2;
        wd_q    <= wd2;
        rd0_q   <= '0;
        rd1_q   <= '0;
      end
      if (state_q == BEAT0 && bus.mem_ready) rd0_q <= bus.mem_rdata;
      if (state_q == BEAT1 && bus.mem_ready) rd1_q <= bus.mem_rdata;
    end
  end
  always_comb begin
    rd2  = {rd1_q, rd0_q} >> (8 * off_q);
    lo   = rd2[XLEN-1:0];
    keep = ~({XLEN{1'b1}} << (8 << sz_q));
    msb  = keep & ~(keep >> 1);
    sign = |(lo & msb);
    ext  = (lo & keep) | ((sign && !uns_q) ? ~keep : '0);
    b1   = state_q == BEAT1;
  end
  assign bus.req_ready  = state_q == IDLE;
  assign bus.mem_valid  = state_q == BEAT0 || b1;
  assign bus.mem_adr    = !bus.mem_valid ? '0 : b1 ? adr_q + ADDR_W'(NB) : adr_q;
  assign bus.mem_we     = bus.mem_valid && write_q;
  assign bus.mem_be     = !bus.mem_valid ? '0 : b1 ? be_q[2*NB-1:NB] : be_q[NB-1:0];
  assign bus.mem_wdata  = !bus.mem_we ? '0 : b1 ? wd_q[2*XLEN-1:XLEN] : wd_q[XLEN-1:0];
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_err   = bus.resp_valid && err_q;
  assign bus.resp_rdata = (bus.resp_valid && !err_q && !write_q) ? ext : '0;
endmodule

// File: tb/tb_lsu_multibeat.sv
// tb_lsu_multibeat: directed checks of the load/store unit (XLEN=32); follows the LSU_MISALIGN_SPLIT_EN build setting.
module tb_lsu_multibeat;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int seen;
  lsu_multibeat_if #(.XLEN(32), .ADDR_W(32)) bus ();
  lsu_multibeat #(.XLEN(32), .ADDR_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(negedge clk);
    bus.req_valid  = 1'b0;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.mem_ready = 1'b1; bus.mem_rdata = '0;
    #3;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_mem_valid", bus.mem_valid, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_mem_be", bus.mem_be, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // SW aligned
    issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    chk("sw_mem_valid", bus.mem_valid, 1);
    chk("sw_adr", bus.mem_adr, 32'h100);
    chk("sw_be", bus.mem_be, 4'b1111);
    chk("sw_we", bus.mem_we, 1);
    chk("sw_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("sw_req_ready_busy", bus.req_ready, 0);
    chk("sw_no_early_resp", bus.resp_valid, 0);
    @(negedge clk);
    chk("sw_resp_valid", bus.resp_valid, 1);
    chk("sw_resp_err", bus.resp_err, 0);
    chk("sw_resp_rdata", bus.resp_rdata, 0);
    chk("sw_resp_mem_valid", bus.mem_valid, 0);
    @(negedge clk);
    chk("sw_resp_pulse", bus.resp_valid, 0);
    chk("sw_idle_ready", bus.req_ready, 1);
    // LB / LBU at byte 3
    bus.mem_rdata = 32'h80FF1234;
    issue(1'b0, 3'b000, 32'h203, 32'h0);
    chk("lb_adr", bus.mem_adr, 32'h200);
    chk("lb_be", bus.mem_be, 4'b1000);
    chk("lb_we", bus.mem_we, 0);
    @(negedge clk);
    chk("lb_rdata", bus.resp_rdata, 32'hFFFFFF80);
    @(negedge clk);
    issue(1'b0, 3'b100, 32'h203, 32'h0);
    @(negedge clk);
    chk("lbu_rdata", bus.resp_rdata, 32'h00000080);
    @(negedge clk);
    // LH / LHU upper half
    issue(1'b0, 3'b001, 32'h202, 32'h0);
    chk("lh_be", bus.mem_be, 4'b1100);
    @(negedge clk);
    chk("lh_rdata", bus.resp_rdata, 32'hFFFF80FF);
    @(negedge clk);
    issue(1'b0, 3'b101, 32'h202, 32'h0);
    @(negedge clk);
    chk("lhu_rdata", bus.resp_rdata, 32'h000080FF);
    @(negedge clk);
    // SH at offset 2, SB at offset 1
    issue(1'b1, 3'b001, 32'h102, 32'h0000ABCD);
    chk("sh_adr", bus.mem_adr, 32'h100);
    chk("sh_be", bus.mem_be, 4'b1100);
    chk("sh_wdata", bus.mem_wdata, 32'hABCD0000);
    @(negedge clk);
    @(negedge clk);
    issue(1'b1, 3'b000, 32'h101, 32'h0000005A);
    chk("sb_be", bus.mem_be, 4'b0010);
    chk("sb_wdata", bus.mem_wdata, 32'h00005A00);
    @(negedge clk);
    @(negedge clk);
    // LW misaligned
    bus.mem_rdata = 32'h44332211;
    issue(1'b0, 3'b010, 32'h101, 32'h0);
`ifdef LSU_MISALIGN_SPLIT_EN
    chk("lwm_b0_adr", bus.mem_adr, 32'h100);
    chk("lwm_b0_be", bus.mem_be, 4'b1110);
    @(negedge clk);
    bus.mem_rdata = 32'h88776655;
    chk("lwm_b1_valid", bus.mem_valid, 1);
    chk("lwm_b1_adr", bus.mem_adr, 32'h104);
    chk("lwm_b1_be", bus.mem_be, 4'b0001);
    chk("lwm_b1_no_resp", bus.resp_valid, 0);
    @(negedge clk);
    chk("lwm_resp_valid", bus.resp_valid, 1);
    chk("lwm_resp_err", bus.resp_err, 0);
    chk("lwm_rdata", bus.resp_rdata, 32'h55443322);
    @(negedge clk);
    // misaligned SW across the top of the address space
    issue(1'b1, 3'b010, 32'hFFFFFFFE, 32'hA1B2C3D4);
    chk("swm_b0_adr", bus.mem_adr, 32'hFFFFFFFC);
    chk("swm_b0_be", bus.mem_be, 4'b1100);
    chk("swm_b0_wdata", bus.mem_wdata, 32'hC3D40000);
    @(negedge clk);
    chk("swm_b1_adr_wrap", bus.mem_adr, 32'h0);
    chk("swm_b1_be", bus.mem_be, 4'b0011);
    chk("swm_b1_wdata", bus.mem_wdata, 32'h0000A1B2);
    @(negedge clk);
    chk("swm_resp", bus.resp_valid, 1);
    @(negedge clk);
`else
    chk("lwm_no_mem", bus.mem_valid, 0);
    chk("lwm_resp_valid", bus.resp_valid, 1);
    chk("lwm_resp_err", bus.resp_err, 1);
    chk("lwm_rdata", bus.resp_rdata, 0);
    @(negedge clk);
    chk("lwm_idle", bus.req_ready, 1);
`endif
    // illegal funct3 cases: 011 load, 100 store, 111, 110 load (XLEN=32)
    issue(1'b0, 3'b011, 32'h100, 32'h0);
    chk("ld_f3_011_mem", bus.mem_valid, 0);
    chk("ld_f3_011_err", bus.resp_err, 1);
    @(negedge clk);
    issue(1'b1, 3'b100, 32'h100, 32'h0);
    chk("st_f3_100_mem", bus.mem_valid, 0);
    chk("st_f3_100_err", bus.resp_err, 1);
    @(negedge clk);
    issue(1'b0, 3'b111, 32'h100, 32'h0);
    chk("ld_f3_111_err", bus.resp_err, 1);
    @(negedge clk);
    issue(1'b0, 3'b110, 32'h100, 32'h0);
    chk("ld_f3_110_err", bus.resp_err, 1);
    chk("ld_f3_110_mem", bus.mem_valid, 0);
    @(negedge clk);
    // stall with mem_ready low, then async reset mid-stall
    bus.mem_ready = 1'b0;
    issue(1'b0, 3'b010, 32'h200, 32'h0);
    for (int i = 0; i < 3; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h300;
      chk("stall_valid", bus.mem_valid, 1);
      chk("stall_adr", bus.mem_adr, 32'h200);
      chk("stall_be", bus.mem_be, 4'b1111);
      chk("stall_req_ready", bus.req_ready, 0);
      chk("stall_no_resp", bus.resp_valid, 0);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_valid", bus.mem_valid, 0);
    chk("arst_req_ready", bus.req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.resp_valid || bus.mem_valid) seen++;
    end
    chk("arst_no_resp", seen, 0);
    chk("arst_idle_ready", bus.req_ready, 1);
    // after reset the unit still works
    bus.mem_rdata = 32'h12345678;
    issue(1'b0, 3'b010, 32'h400, 32'h0);
    @(negedge clk);
    chk("post_lw_rdata", bus.resp_rdata, 32'h12345678);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
